// File: rtl/int_countdn_proc_n.sv
// Interrupt latch and countdown processor.
// External interrupt discretes are synchronised, edge-captured on the
// timing-phase SAMPLE strobe and held as pending bits until acknowledged.
// An internal countdown timer is the extra channel at index NCH. Pending
// bits are masked and priority-encoded into SINT/INT_ID. Repeated sets on
// a bit that is still pending are recorded as sticky overruns.
module int_countdn_proc_n #(
  parameter int NCH         = 7,
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_RELOAD = 0,
  localparam int IDW        = $clog2(NCH + 1)
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             SAMPLE,
  input  logic [NCH-1:0]   INTR,
  input  logic             MASK_WR,
  input  logic [NCH:0]     MASK_D,
  output logic [NCH:0]     MASK_Q,
  input  logic             INT_ACK,
  input  logic [IDW-1:0]   ACK_ID,
  output logic [NCH:0]     PEND,
  output logic             SINT,
  output logic             SINTN,
  output logic [IDW-1:0]   INT_ID,
  output logic [NCH:0]     OVR,
  input  logic             CNT_LOAD,
  input  logic [CNT_W-1:0] CNT_D,
  input  logic             CNT_TICK,
  output logic [CNT_W-1:0] CNT_Q,
  output logic             TC
);

  // Lowest set index wins; scanning downwards lets the lowest index
  // overwrite any higher one found earlier. Returns 0 for an empty vector.
  function automatic logic [IDW-1:0] prio_enc(input logic [NCH:0] v);
    logic [IDW-1:0] id;
    id = '0;
    for (int k = NCH; k >= 0; k--) begin
      if (v[k]) id = IDW'(k);
    end
    return id;
  endfunction

  // Next counter value for a tick: decrement above 1, terminal at 1
  // (reload or stop at zero), and hold at 0 without wrapping.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic [CNT_W-1:0] rld);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (cur > CNT_W'(1)) begin
      nxt = cur - CNT_W'(1);
    end else if (cur == CNT_W'(1)) begin
      nxt = (AUTO_RELOAD != 0) ? rld : '0;
    end
    return nxt;
  endfunction

  logic [NCH-1:0]   sync_p0 [SYNC_STAGES];
  logic [NCH-1:0]   s_p1;
  logic [NCH-1:0]   prev_p1;
  logic [NCH-1:0]   rise_p1;
  logic [NCH:0]     set_src;
  logic [NCH:0]     ack_vec;
  logic [NCH:0]     pend_q;
  logic [NCH:0]     ovr_q;
  logic [NCH:0]     mask_q;
  logic [NCH:0]     active;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] reload_q;
  logic             tc_q;

  // ---- stage p0: metastability synchroniser chain for the raw discretes
  // Shift each INTR bit through SYNC_STAGES flops.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
    end else begin
      sync_p0[0] <= INTR;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  // ---- stage p1: edge detection against the level seen at the last strobe
  assign s_p1 = sync_p0[SYNC_STAGES-1];

  // Remember the synchronised level only on SAMPLE strobes, so a held level
  // yields a single capture no matter how many strobes pass.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      prev_p1 <= '0;
    end else if (SAMPLE) begin
      prev_p1 <= s_p1;
    end
  end

  assign rise_p1 = SAMPLE ? (s_p1 & ~prev_p1) : '0;

  // The timer channel is set straight from the registered TC pulse.
  assign set_src = {tc_q, rise_p1};

  // Decode the acknowledge; IDs above NCH match no bit and are ignored.
  always_comb begin
    ack_vec = '0;
    for (int k = 0; k <= NCH; k++) begin
      ack_vec[k] = INT_ACK && (ACK_ID == IDW'(k));
    end
  end

  // ---- stage p2: pending and overrun latches
  // A set beats an ack on the same bit. Overrun records a set landing on a
  // still-pending bit unless that bit is being acknowledged in the same
  // cycle; it clears only on an ack that is not racing a new set.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= set_src | (pend_q & ~ack_vec);
      ovr_q  <= (ovr_q & ~(ack_vec & ~set_src)) |
                (set_src & pend_q & ~ack_vec);
    end
  end

  // Mask register; resets to all channels enabled.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      mask_q <= '1;
    end else if (MASK_WR) begin
      mask_q <= MASK_D;
    end
  end

  // Countdown timer. Load beats tick; TC is a one-cycle registered pulse
  // emitted when a tick arrives at a count of 1.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (CNT_LOAD) begin
        cnt_q    <= CNT_D;
        reload_q <= CNT_D;
      end else if (CNT_TICK) begin
        cnt_q <= cnt_step(cnt_q, reload_q);
        tc_q  <= (cnt_q == CNT_W'(1));
      end
    end
  end

  // ---- output: summary interrupt straight from the registered state
  assign active = pend_q & mask_q;
  assign SINT   = |active;
  assign SINTN  = ~SINT;
  assign INT_ID = prio_enc(active);

  assign MASK_Q = mask_q;
  assign PEND   = pend_q;
  assign OVR    = ovr_q;
  assign CNT_Q  = cnt_q;
  assign TC     = tc_q;

endmodule

// File: tb/tb_int_countdn_proc_n.sv
// Directed bench for int_countdn_proc_n: one instance without auto-reload
// and one with auto-reload, both driven by the same stimulus.
module tb_int_countdn_proc_n;

  localparam int NCH = 7;
  localparam int CW  = 10;
  localparam int IDW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample;
  logic [NCH-1:0] intr;
  logic          mask_wr;
  logic [NCH:0]  mask_d;
  logic          int_ack;
  logic [IDW-1:0] ack_id;
  logic          cnt_load;
  logic [CW-1:0] cnt_d;
  logic          cnt_tick;

  logic [NCH:0]  mask_q, pend, ovr;
  logic          sint, sintn, tc;
  logic [IDW-1:0] int_id;
  logic [CW-1:0] cnt_q;

  logic [NCH:0]  mask_q_1, pend_1, ovr_1;
  logic          sint_1, sintn_1, tc_1;
  logic [IDW-1:0] int_id_1;
  logic [CW-1:0] cnt_q_1;

  int vectors = 0;
  int miss    = 0;

  always #5 clk = ~clk;

  int_countdn_proc_n #(.NCH(NCH), .CNT_W(CW), .SYNC_STAGES(2), .AUTO_RELOAD(0)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .SAMPLE(sample), .INTR(intr),
    .MASK_WR(mask_wr), .MASK_D(mask_d), .MASK_Q(mask_q),
    .INT_ACK(int_ack), .ACK_ID(ack_id), .PEND(pend),
    .SINT(sint), .SINTN(sintn), .INT_ID(int_id), .OVR(ovr),
    .CNT_LOAD(cnt_load), .CNT_D(cnt_d), .CNT_TICK(cnt_tick),
    .CNT_Q(cnt_q), .TC(tc)
  );

  int_countdn_proc_n #(.NCH(NCH), .CNT_W(CW), .SYNC_STAGES(2), .AUTO_RELOAD(1)) dut_ar (
    .SIM_CLK(clk), .SIM_RST(rst), .SAMPLE(sample), .INTR(intr),
    .MASK_WR(mask_wr), .MASK_D(mask_d), .MASK_Q(mask_q_1),
    .INT_ACK(int_ack), .ACK_ID(ack_id), .PEND(pend_1),
    .SINT(sint_1), .SINTN(sintn_1), .INT_ID(int_id_1), .OVR(ovr_1),
    .CNT_LOAD(cnt_load), .CNT_D(cnt_d), .CNT_TICK(cnt_tick),
    .CNT_Q(cnt_q_1), .TC(tc_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pulse();
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  task automatic sync_wait();
    step();
    step();
  endtask

  task automatic ack(input logic [IDW-1:0] id);
    int_ack = 1'b1;
    ack_id  = id;
    step();
    int_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; intr = '0; mask_wr = 1'b0; mask_d = '0;
    int_ack = 1'b0; ack_id = '0; cnt_load = 1'b0; cnt_d = '0; cnt_tick = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_pend",  pend,   32'h00);
    chk("rst_ovr",   ovr,    32'h00);
    chk("rst_mask",  mask_q, 32'hFF);
    chk("rst_cnt",   cnt_q,  32'h0);
    chk("rst_tc",    tc,     32'h0);
    chk("rst_sint",  sint,   32'h0);
    chk("rst_sintn", sintn,  32'h1);
    chk("rst_id",    int_id, 32'h0);

    // Held level on INTR[2]: one capture, no overrun on later strobes
    intr = 7'h04;
    sync_wait();
    chk("t1_no_sample", pend, 32'h00);
    sample_pulse();
    chk("t1_pend",  pend,   32'h04);
    chk("t1_sint",  sint,   32'h1);
    chk("t1_sintn", sintn,  32'h0);
    chk("t1_id",    int_id, 32'h2);
    repeat (7) step();
    sample_pulse();
    chk("t1_pend2", pend, 32'h04);
    chk("t1_ovr",   ovr,  32'h00);
    ack(3'd2);
    chk("t1_ack", pend, 32'h00);
    sample_pulse();
    chk("t1_held_once", pend, 32'h00);
    intr = '0;
    sync_wait();
    sample_pulse();

    // Two simultaneous captures, priority and acks
    intr = 7'h22;
    sync_wait();
    sample_pulse();
    chk("t2_pend", pend,   32'h22);
    chk("t2_id1",  int_id, 32'h1);
    ack(3'd1);
    chk("t2_id5",  int_id, 32'h5);
    ack(3'd5);
    chk("t2_sint", sint,   32'h0);
    chk("t2_id0",  int_id, 32'h0);
    intr = '0;
    sync_wait();
    sample_pulse();

    // Masking hides SINT but not latching
    mask_d = 8'h7D; mask_wr = 1'b1;
    step();
    mask_wr = 1'b0;
    chk("t3_mask", mask_q, 32'h7D);
    intr = 7'h02;
    sync_wait();
    sample_pulse();
    chk("t3_pend",  pend,   32'h02);
    chk("t3_sint0", sint,   32'h0);
    chk("t3_id0",   int_id, 32'h0);
    mask_d = 8'hFF; mask_wr = 1'b1;
    step();
    mask_wr = 1'b0;
    chk("t3_sint1", sint,   32'h1);
    chk("t3_id1",   int_id, 32'h1);
    ack(3'd1);
    intr = '0;
    sync_wait();
    sample_pulse();
    chk("t3_clear", pend, 32'h00);

    // Overrun on INTR[3], then ack racing a new capture
    intr = 7'h08;
    sync_wait();
    sample_pulse();
    chk("t4_pend", pend, 32'h08);
    intr = '0;
    sync_wait();
    sample_pulse();
    intr = 7'h08;
    sync_wait();
    sample_pulse();
    chk("t4_ovr",  ovr,  32'h08);
    chk("t4_pend2", pend, 32'h08);
    intr = '0;
    sync_wait();
    sample_pulse();
    intr = 7'h08;
    sync_wait();
    sample = 1'b1; int_ack = 1'b1; ack_id = 3'd3;
    step();
    sample = 1'b0; int_ack = 1'b0;
    chk("t4_race_pend", pend, 32'h08);
    chk("t4_race_ovr",  ovr,  32'h08);
    ack(3'd3);
    chk("t4_ack_pend", pend, 32'h00);
    chk("t4_ack_ovr",  ovr,  32'h00);
    intr = '0;

    // Countdown without reload
    cnt_d = 10'd3; cnt_load = 1'b1;
    step();
    cnt_load = 1'b0;
    chk("t5_load", cnt_q, 32'd3);
    cnt_tick = 1'b1;
    step();
    chk("t5_c2", cnt_q, 32'd2);
    chk("t5_tc_a", tc, 32'h0);
    step();
    chk("t5_c1", cnt_q, 32'd1);
    step();
    cnt_tick = 1'b0;
    chk("t5_c0", cnt_q, 32'd0);
    chk("t5_tc", tc, 32'h1);
    chk("t5_pend_pre", pend, 32'h00);
    step();
    chk("t5_tc_off", tc, 32'h0);
    chk("t5_pend7", pend, 32'h80);
    chk("t5_id7", int_id, 32'h7);
    cnt_tick = 1'b1;
    step();
    cnt_tick = 1'b0;
    chk("t5_hold0", cnt_q, 32'd0);
    chk("t5_no_tc", tc, 32'h0);
    ack(3'd7);
    chk("t5_ack7", pend, 32'h00);
    cnt_d = 10'd0; cnt_load = 1'b1;
    step();
    cnt_load = 1'b0; cnt_tick = 1'b1;
    step();
    cnt_tick = 1'b0;
    chk("t5_load0_tc", tc, 32'h0);

    // Auto-reload instance: period-2 terminal counts
    cnt_d = 10'd2; cnt_load = 1'b1;
    step();
    cnt_load = 1'b0;
    chk("t6_load", cnt_q_1, 32'd2);
    cnt_tick = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("t6_cnt%0d", i), cnt_q_1, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("t6_tc%0d", i),  tc_1,    (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    cnt_tick = 1'b0;

    // Load beats tick
    cnt_d = 10'd9; cnt_load = 1'b1; cnt_tick = 1'b1;
    step();
    cnt_load = 1'b0; cnt_tick = 1'b0;
    chk("t6_ld_tick",  cnt_q,   32'd9);
    chk("t6_ld_tick1", cnt_q_1, 32'd9);

    // Reset at count 1 abandons the count
    ack(3'd7);
    cnt_d = 10'd1; cnt_load = 1'b1;
    step();
    cnt_load = 1'b0;
    chk("t6_c1", cnt_q_1, 32'd1);
    rst = 1'b1; cnt_tick = 1'b1;
    step();
    chk("t6_rst_cnt",  cnt_q_1, 32'd0);
    chk("t6_rst_tc",   tc_1,    32'h0);
    chk("t6_rst_cnt0", cnt_q,   32'd0);
    chk("t6_rst_tc0",  tc,      32'h0);
    rst = 1'b0; cnt_tick = 1'b0;
    step();
    chk("t6_post_tc",   tc_1,   32'h0);
    chk("t6_post_pend", pend_1, 32'h00);

    // Reload value of 1: TC on every tick
    cnt_d = 10'd1; cnt_load = 1'b1;
    step();
    cnt_load = 1'b0; cnt_tick = 1'b1;
    step();
    chk("t6_r1_cnt_a", cnt_q_1, 32'd1);
    chk("t6_r1_tc_a",  tc_1,    32'h1);
    chk("t6_nr_tc_a",  tc,      32'h1);
    step();
    cnt_tick = 1'b0;
    chk("t6_r1_tc_b",  tc_1,    32'h1);
    chk("t6_nr_tc_b",  tc,      32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/int_countdn_proc_n.md
Name: int_countdn_proc_n

Overview:
- Parametrised interrupt-latch and countdown processor for the LVDA.
- Captures NCH discrete interrupt lines on a timing-phase sample strobe and holds each as a pending bit until acknowledged.
- Adds one internal countdown-timer channel; all pending bits are masked and priority-encoded into a summary interrupt SINT with a channel ID.
- Replaces the fixed 7-input interrupt/countdown logic with configurable channel count, counter width, per-channel masking, overrun detection and optional auto-reload.

Parameters:
- NCH, 7, number of external interrupt channels (1..30).
- CNT_W, 10, countdown counter width in bits.
- SYNC_STAGES, 2, synchroniser flops per external input (>=1).
- AUTO_RELOAD, 0, 1 = counter reloads from the last loaded value on terminal count.
- IDW, derived ceil(log2(NCH+1)), width of the channel ID.

Ports:
- SIM_CLK  in  1  system clock; all logic on rising edge.
- SIM_RST  in  1  synchronous active-high reset.
- SAMPLE  in  1  one-cycle timing-phase strobe; external capture occurs only when high.
- INTR  in  NCH  raw active-high interrupt discretes, asynchronous.
- MASK_WR  in  1  write enable for the mask register.
- MASK_D  in  NCH+1  mask write data; 1 = enabled; bit NCH is the timer channel.
- MASK_Q  out  NCH+1  current mask.
- INT_ACK  in  1  clear the pending bit selected by ACK_ID.
- ACK_ID  in  IDW  channel to clear; values >NCH are ignored.
- PEND  out  NCH+1  pending bits, unmasked.
- SINT  out  1  summary interrupt: OR of PEND & MASK_Q.
- SINTN  out  1  complement of SINT.
- INT_ID  out  IDW  lowest-index masked pending channel; 0 when SINT=0.
- OVR  out  NCH+1  sticky overrun per channel.
- CNT_LOAD  in  1  load countdown counter.
- CNT_D  in  CNT_W  load value.
- CNT_TICK  in  1  decrement strobe.
- CNT_Q  out  CNT_W  counter value.
- TC  out  1  one-cycle terminal-count pulse.

Behaviour:
- Reset (SIM_RST=1 at an edge) sets:
  - PEND=0, OVR=0, CNT_Q=0, TC=0, reload register=0.
  - MASK_Q = all ones.
  - Synchroniser flops and the previous-sample register = 0.
  - SINT=0, SINTN=1, INT_ID=0.
- Reset overrides every other input in the same cycle. Reset mid-count abandons the count with no TC.
- Synchronisation: each INTR bit passes through SYNC_STAGES flops to give s.
- Edge capture: on a cycle with SAMPLE=1, rise = s & ~prev, then prev <= s. prev does not change when SAMPLE=0.
  - Result: a level held high gives exactly one capture.
  - Pulses shorter than the spacing between SAMPLE strobes may be missed.
- Latency: INTR rising to PEND set = SYNC_STAGES cycles + wait for the next SAMPLE + 1 cycle.
- Pending set/clear:
  - A set source for bit k (rise[k], or TC for k=NCH) sets PEND[k] at the next edge.
  - If PEND[k] is already 1 when a set source arrives, OVR[k] is set too.
  - INT_ACK with ACK_ID=k clears PEND[k] at the next edge.
  - Simultaneous set and ack on the same bit: set wins, OVR not set.
  - OVR[k] clears only when INT_ACK targets k while no new set arrives for k that cycle.
- Mask:
  - MASK_WR loads MASK_D at the next edge.
  - Masking does not block latching; PEND still sets and still counts overruns.
- SINT, SINTN and INT_ID are combinational from the PEND and MASK_Q registers, with no added latency.
- INT_ID uses fixed priority: the lowest index wins; the timer (index NCH) has the lowest priority.
- Counter:
  - CNT_LOAD: CNT_Q <= CNT_D and reload <= CNT_D. Load wins over a tick in the same cycle.
  - CNT_TICK with CNT_Q>1: decrement by 1.
  - CNT_TICK with CNT_Q==1: TC=1 for the next cycle. CNT_Q becomes reload if AUTO_RELOAD=1, else 0.
  - CNT_TICK with CNT_Q==0: no change, no TC, no wrap.
  - Loading 0 never produces TC.
  - AUTO_RELOAD with reload==1 gives TC on every tick.
- The TC pulse sets PEND[NCH] directly, with no SAMPLE dependence: PEND[NCH] is 1 in the cycle after TC.

Test Plan:
- Reset, then INTR[2]=1 held; SAMPLE every 8 cycles -> PEND=0x004 once, SINT=1, INT_ID=2. A second SAMPLE with INTR still high -> OVR stays 0.
- INTR[5] and INTR[1] rise together, SAMPLE -> INT_ID=1. ACK_ID=1 -> INT_ID=5. ACK_ID=5 -> SINT=0, INT_ID=0.
- MASK_D=0x7D (bit1 off), INTR[1] rises -> PEND[1]=1, SINT=0. Re-enable the mask -> SINT=1 the cycle after MASK_WR.
- PEND[3]=1, INTR[3] drops and rises again, then SAMPLE -> OVR[3]=1. Ack on the same cycle as a new capture -> PEND[3] stays 1.
- CNT_D=3, load, 3 ticks -> CNT_Q 3,2,1,0, then TC pulse for 1 cycle, then PEND[7]=1. A 4th tick -> CNT_Q=0, no TC.
- AUTO_RELOAD=1, CNT_D=2, 6 ticks -> TC after ticks 2, 4, 6. CNT_LOAD and CNT_TICK together with CNT_D=9 -> CNT_Q=9. SIM_RST at count 1 -> CNT_Q=0, no TC.
